// File: rtl/sram_pkg.sv
// Shared types and constants for the banked on-chip SRAM.
// Host bus widths, FSM state encoding and a width helper.
package sram_pkg;

  localparam int ADR_W = 21;
  localparam int DAT_W = 16;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    BUSY,
    ACK
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/baseram.sv
// Single-port RAM with byte enables and registered read data.
// Behavioural stand-in for the altsyncram primitive.
module baseram #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic            clock,
  input  logic [AW-1:0]   address,
  input  logic [DW-1:0]   data,
  input  logic [DW/8-1:0] byteena,
  input  logic            wren,
  input  logic            rden,
  output logic [DW-1:0]   q
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (wren) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (byteena[b]) mem[address][b*8 +: 8] <= data[b*8 +: 8];
      end
    end
    if (rden) q <= mem[address];
  end

endmodule

// File: rtl/sram_bank_mux.sv
// Bank decode: gates per-bank strobes and returns the selected q.
// Indices past the last bank select nothing and read as zero.
module sram_bank_mux
  import sram_pkg::*;
#(
  parameter int NBANKS = 1,
  parameter int BW     = 5
) (
  input  logic [BW-1:0]    bank,
  input  logic             rd,
  input  logic             wr,
  input  logic [DAT_W-1:0] q_all [NBANKS],
  output logic [NBANKS-1:0] rden,
  output logic [NBANKS-1:0] wren,
  output logic [DAT_W-1:0] q
);

  always_comb begin
    rden = '0;
    wren = '0;
    q    = '0;
    for (int i = 0; i < NBANKS; i++) begin
      if (int'(bank) == i) begin
        rden[i] = rd;
        wren[i] = wr;
        q       = q_all[i];
      end
    end
  end

endmodule

// File: rtl/sram_banked.sv
// Banked on-chip SRAM behind the sdram_* host bus.
// Fixed-latency acknowledge, optional zero fill after reset.
module sram_banked
  import sram_pkg::*;
#(
  parameter int NBANKS         = 1,
  parameter int BANK_AW        = 16,
  parameter int ACK_DELAY      = 7,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             clk_p,
  input  logic             sdram_reset,
  input  logic             sdram_stb,
  input  logic             sdram_we,
  input  logic [SEL_W-1:0] sdram_sel,
  input  logic [ADR_W:1]   sdram_adr,
  input  logic [DAT_W-1:0] sdram_out,
  output logic             sdram_ack,
  output logic [DAT_W-1:0] sdram_dat,
  output logic             sdram_ready
);

  localparam int BW = ADR_W - BANK_AW;
  localparam int CW = clog2(ACK_DELAY);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [BANK_AW-1:0] clr_adr;
  logic [BW-1:0]      bank_reg;
  logic [BANK_AW-1:0] word_reg;
  logic               we_reg;
  logic [DAT_W-1:0]   dat_reg;

  logic               req;
  logic [BW-1:0]      bank;
  logic [BANK_AW-1:0] word;
  logic [DAT_W-1:0]   wdata;
  logic [SEL_W-1:0]   be;
  logic               rd;
  logic               wr;
  logic [NBANKS-1:0]  rden_b;
  logic [NBANKS-1:0]  wren_m;
  logic [NBANKS-1:0]  wren_b;
  logic [DAT_W-1:0]   q_b [NBANKS];
  logic [DAT_W-1:0]   q_mux;

  // Live address in IDLE so the access starts on the sampling edge
  assign req   = (state == IDLE) && sdram_stb && !sdram_reset;
  assign bank  = (state == IDLE) ? sdram_adr[ADR_W:BANK_AW+1] : bank_reg;
  assign word  = (state == CLEAR) ? clr_adr :
                 (state == IDLE)  ? sdram_adr[BANK_AW:1] : word_reg;
  assign wdata = (state == CLEAR) ? '0 : sdram_out;
  assign be    = (state == CLEAR) ? '1 : sdram_sel;
  assign rd    = !sdram_reset &&
                 ((req && !sdram_we) || (state == BUSY && !we_reg));
  assign wr    = req && sdram_we;

  assign wren_b = (state == CLEAR && !sdram_reset) ? '1 : wren_m;

  sram_bank_mux #(
    .NBANKS(NBANKS),
    .BW    (BW)
  ) u_mux (
    .bank (bank),
    .rd   (rd),
    .wr   (wr),
    .q_all(q_b),
    .rden (rden_b),
    .wren (wren_m),
    .q    (q_mux)
  );

  for (genvar i = 0; i < NBANKS; i++) begin : g_bank
    baseram #(
      .AW(BANK_AW),
      .DW(DAT_W)
    ) u_ram (
      .clock  (clk_p),
      .address(word),
      .data   (wdata),
      .byteena(be),
      .wren   (wren_b[i]),
      .rden   (rden_b[i]),
      .q      (q_b[i])
    );
  end

  always_ff @(posedge clk_p) begin
    if (sdram_reset) begin
      state       <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      sdram_ready <= (CLEAR_ON_RESET == 0);
      clr_adr     <= '0;
      cnt         <= '0;
      dat_reg     <= '0;
      bank_reg    <= '0;
      word_reg    <= '0;
      we_reg      <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          clr_adr <= clr_adr + 1'b1;
          if (clr_adr == '1) begin
            state       <= IDLE;
            sdram_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (sdram_stb) begin
            state    <= BUSY;
            cnt      <= CW'(ACK_DELAY - 2);
            bank_reg <= sdram_adr[ADR_W:BANK_AW+1];
            word_reg <= sdram_adr[BANK_AW:1];
            we_reg   <= sdram_we;
          end
        end
        BUSY: begin
          if (!sdram_stb) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= ACK;
            if (!we_reg) dat_reg <= q_mux;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK: begin
          if (!sdram_stb) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sdram_ack = sdram_stb && (state == ACK);
  assign sdram_dat = dat_reg;

endmodule

// File: tb/tb_sram_banked.sv
// Directed bench for sram_banked: 2 banks of 16 words, latency 7.
// Bank index is adr[21:5], word is adr[4:1].
module tb_sram_banked;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  sel = 2'b11;
  logic [20:0] adr = '0;
  logic [15:0] out = '0;
  logic        ack;
  logic [15:0] dat;
  logic        ready;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sram_banked #(
    .NBANKS(2),
    .BANK_AW(4),
    .ACK_DELAY(7),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk_p      (clk),
    .sdram_reset(rst),
    .sdram_stb  (stb),
    .sdram_we   (we),
    .sdram_sel  (sel),
    .sdram_adr  (adr),
    .sdram_out  (out),
    .sdram_ack  (ack),
    .sdram_dat  (dat),
    .sdram_ready(ready)
  );

  task automatic xfer(input logic w, input logic [1:0] s,
                      input logic [20:0] a, input logic [15:0] d,
                      output logic [15:0] rdat, output int lat,
                      output logic fell);
    @(negedge clk);
    stb = 1'b1; we = w; sel = s; adr = a; out = d;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ack) begin lat = i; break; end
    end
    rdat = dat;
    @(negedge clk);
    stb = 1'b0;
    #1 fell = !ack;
    @(posedge clk);
  endtask

  task automatic wait_ready(output int lat, output logic acked);
    lat = 0;
    acked = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ack) acked = 1'b1;
      if (ready) begin lat = i; stb = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    int lat;
    logic acked;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b0 || ack !== 1'b0 || dat !== 16'h0000)
      $display("FAIL reset_state ready=%b ack=%b dat=%h want 0 0 0000",
               ready, ack, dat);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    stb = 1'b1; we = 1'b1; sel = 2'b11; adr = 21'h00005; out = 16'hDEAD;
    wait_ready(lat, acked);
    total++;
    if (lat !== 16)
      $display("FAIL clear_len got %0d want 16", lat);
    else passed++;
    total++;
    if (acked !== 1'b0)
      $display("FAIL clear_stb_ignored ack=%b want 0", acked);
    else passed++;
  endtask

  task automatic test_clear_read;
    logic [15:0] r;
    int lat;
    logic f;
    xfer(1'b0, 2'b11, 21'h00005, 16'h0, r, lat, f);
    total++;
    if (r !== 16'h0000 || lat !== 7)
      $display("FAIL clear_read0 dat=%h lat=%0d want 0000 7", r, lat);
    else passed++;
    xfer(1'b0, 2'b11, 21'h00013, 16'h0, r, lat, f);
    total++;
    if (r !== 16'h0000 || lat !== 7)
      $display("FAIL clear_read1 dat=%h lat=%0d want 0000 7", r, lat);
    else passed++;
  endtask

  task automatic test_write_read;
    logic [15:0] r;
    int lat;
    logic f;
    xfer(1'b1, 2'b11, 21'h00003, 16'hA5C3, r, lat, f);
    total++;
    if (lat !== 7 || f !== 1'b1)
      $display("FAIL wr_bank0 lat=%0d fell=%b want 7 1", lat, f);
    else passed++;
    xfer(1'b1, 2'b11, 21'h00013, 16'h1234, r, lat, f);
    total++;
    if (lat !== 7)
      $display("FAIL wr_bank1 lat=%0d want 7", lat);
    else passed++;
    xfer(1'b0, 2'b11, 21'h00003, 16'h0, r, lat, f);
    total++;
    if (r !== 16'hA5C3 || lat !== 7)
      $display("FAIL rd_bank0 dat=%h lat=%0d want a5c3 7", r, lat);
    else passed++;
    xfer(1'b0, 2'b11, 21'h00013, 16'h0, r, lat, f);
    total++;
    if (r !== 16'h1234 || lat !== 7)
      $display("FAIL rd_bank1 dat=%h lat=%0d want 1234 7", r, lat);
    else passed++;
  endtask

  task automatic test_byte_lane;
    logic [15:0] r;
    int lat;
    logic f;
    xfer(1'b1, 2'b11, 21'h00002, 16'hFFFF, r, lat, f);
    xfer(1'b1, 2'b01, 21'h00002, 16'h00AB, r, lat, f);
    xfer(1'b0, 2'b11, 21'h00002, 16'h0, r, lat, f);
    total++;
    if (r !== 16'hFFAB)
      $display("FAIL byte_low dat=%h want ffab", r);
    else passed++;
    xfer(1'b1, 2'b10, 21'h00002, 16'h5500, r, lat, f);
    xfer(1'b0, 2'b11, 21'h00002, 16'h0, r, lat, f);
    total++;
    if (r !== 16'h55AB)
      $display("FAIL byte_high dat=%h want 55ab", r);
    else passed++;
  endtask

  task automatic test_out_of_range;
    logic [15:0] r;
    int lat;
    logic f;
    xfer(1'b1, 2'b11, 21'h00023, 16'hBEEF, r, lat, f);
    total++;
    if (lat !== 7)
      $display("FAIL oor_wr_ack lat=%0d want 7", lat);
    else passed++;
    xfer(1'b1, 2'b11, 21'h100003, 16'hBEEF, r, lat, f);
    xfer(1'b0, 2'b11, 21'h00003, 16'h0, r, lat, f);
    xfer(1'b0, 2'b11, 21'h00023, 16'h0, r, lat, f);
    total++;
    if (r !== 16'h0000 || lat !== 7)
      $display("FAIL oor_rd dat=%h lat=%0d want 0000 7", r, lat);
    else passed++;
    xfer(1'b0, 2'b11, 21'h100013, 16'h0, r, lat, f);
    total++;
    if (r !== 16'h0000 || lat !== 7)
      $display("FAIL oor_high_rd dat=%h lat=%0d want 0000 7", r, lat);
    else passed++;
    xfer(1'b0, 2'b11, 21'h00003, 16'h0, r, lat, f);
    total++;
    if (r !== 16'hA5C3)
      $display("FAIL oor_bank0_kept dat=%h want a5c3", r);
    else passed++;
    xfer(1'b0, 2'b11, 21'h00013, 16'h0, r, lat, f);
    total++;
    if (r !== 16'h1234)
      $display("FAIL oor_bank1_kept dat=%h want 1234", r);
    else passed++;
  endtask

  task automatic test_long_write;
    logic [15:0] r;
    int lat;
    int first;
    logic f;
    logic hi;
    first = 0;
    hi = 1'b1;
    @(negedge clk);
    stb = 1'b1; we = 1'b1; sel = 2'b11; adr = 21'h00007; out = 16'h1111;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack && first == 0) first = i;
      if (i > 7 && !ack) hi = 1'b0;
      @(negedge clk);
      out = 16'h2000 + 16'(i);
    end
    stb = 1'b0;
    #1 f = !ack;
    @(posedge clk);
    total++;
    if (first !== 7 || hi !== 1'b1)
      $display("FAIL long_ack first=%0d held=%b want 7 1", first, hi);
    else passed++;
    total++;
    if (f !== 1'b1)
      $display("FAIL long_ack_drop fell=%b want 1", f);
    else passed++;
    total++;
    if (dat !== 16'h1234)
      $display("FAIL wr_keeps_dat dat=%h want 1234", dat);
    else passed++;
    xfer(1'b0, 2'b11, 21'h00007, 16'h0, r, lat, f);
    total++;
    if (r !== 16'h1111)
      $display("FAIL long_wr_data dat=%h want 1111", r);
    else passed++;
  endtask

  task automatic test_abort_read;
    logic [15:0] r;
    int lat;
    logic f;
    logic acked;
    xfer(1'b0, 2'b11, 21'h00003, 16'h0, r, lat, f);
    acked = 1'b0;
    @(negedge clk);
    stb = 1'b1; we = 1'b0; adr = 21'h00013;
    repeat (3) @(posedge clk);
    @(negedge clk);
    stb = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ack) acked = 1'b1;
    end
    total++;
    if (acked !== 1'b0 || dat !== 16'hA5C3)
      $display("FAIL abort_read ack=%b dat=%h want 0 a5c3", acked, dat);
    else passed++;
  endtask

  task automatic test_reset_busy;
    logic [15:0] r;
    int lat;
    logic f;
    logic acked;
    @(negedge clk);
    stb = 1'b1; we = 1'b0; adr = 21'h00003;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ready !== 1'b0 || ack !== 1'b0)
      $display("FAIL rst_busy ready=%b ack=%b want 0 0", ready, ack);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    stb = 1'b0;
    wait_ready(lat, acked);
    total++;
    if (lat !== 16 || acked !== 1'b0)
      $display("FAIL rst_busy_clear lat=%0d ack=%b want 16 0", lat, acked);
    else passed++;
    xfer(1'b0, 2'b11, 21'h00003, 16'h0, r, lat, f);
    total++;
    if (r !== 16'h0000)
      $display("FAIL reclear_bank0 dat=%h want 0000", r);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_clear_read();
    test_write_read();
    test_byte_lane();
    test_out_of_range();
    test_long_write();
    test_abort_read();
    test_reset_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
